// File: rtl/aes_pkcs7_framer.sv
// aes_pkcs7_framer: builds the input stream for the iterative AES-128 ECB core.
// Each packet goes out as four key words, then the plaintext, then PKCS#7
// padding up to the next 16-byte boundary. tlast marks the final padded beat.
module aes_pkcs7_framer #(
   parameter int AXIS_WIDTH = 32
) (
   input  logic                    Clk,
   input  logic                    Rst_n,
   input  logic [127:0]            Key,
   input  logic [AXIS_WIDTH-1:0]   S_axis_tdata,
   input  logic [AXIS_WIDTH/8-1:0] S_axis_tkeep,
   input  logic                    S_axis_tvalid,
   output logic                    S_axis_tready,
   input  logic                    S_axis_tlast,
   output logic [AXIS_WIDTH-1:0]   M_axis_tdata,
   output logic [AXIS_WIDTH/8-1:0] M_axis_tkeep,
   output logic                    M_axis_tvalid,
   input  logic                    M_axis_tready,
   output logic                    M_axis_tlast
);

   typedef enum logic [3:0] {
      ST_IDLE    = 4'b0001,
      ST_KEY_OUT = 4'b0010,
      ST_DATA    = 4'b0100,
      ST_PAD     = 4'b1000
   } state_t;

   state_t        state;
   logic [127:0]  key_reg;
   logic [1:0]    key_cnt;
   logic [1:0]    word_idx;
   logic [2:0]    pad_cnt;
   logic [4:0]    pad_n;

   logic [2:0]    lane_v;
   logic [4:0]    n_calc;
   logic [31:0]   last_data;
   logic          block_full_end;

   // Number of valid leading byte lanes; a hole in tkeep ends the valid run.
   function automatic logic [2:0] lead_ones(input logic [3:0] keep);
      logic [2:0] cnt;
      logic       run;
      cnt = 3'd0;
      run = 1'b1;
      for (int i = 0; i < 4; i++) begin
         run = run & keep[i];
         cnt = cnt + {2'b00, run};
      end
      return cnt;
   endfunction

   // PKCS#7 pad byte: bytes missing to the block end, a full extra block when aligned.
   function automatic logic [4:0] pad_value(input logic [1:0] wi, input logic [2:0] v);
      logic [4:0] used;
      used = {1'b0, wi, 2'b00} + {2'b00, v};
      return (used == 5'd16) ? 5'd16 : 5'd16 - used;
   endfunction

   // Pad byte and merged last beat, derived from the tlast beat currently offered.
   always_comb begin
      lane_v    = lead_ones(S_axis_tkeep);
      n_calc    = pad_value(word_idx, lane_v);
      last_data = S_axis_tdata;
      for (int i = 0; i < 4; i++) begin
         if (3'(i) >= lane_v) begin
            last_data[8*i +: 8] = {3'b000, n_calc};
         end
      end
      block_full_end = (lane_v != 3'd4) && (word_idx == 2'd3);
   end

   // Output muxing: key words, pass-through data, or pad words; idle drives zeros.
   always_comb begin
      M_axis_tvalid = 1'b0;
      M_axis_tdata  = '0;
      M_axis_tlast  = 1'b0;
      S_axis_tready = 1'b0;
      unique case (state)
         ST_KEY_OUT: begin
            M_axis_tvalid = 1'b1;
            M_axis_tdata  = key_reg[{key_cnt, 5'b00000} +: 32];
         end
         ST_DATA: begin
            M_axis_tvalid = S_axis_tvalid;
            S_axis_tready = M_axis_tready;
            M_axis_tdata  = S_axis_tlast ? last_data : S_axis_tdata;
            M_axis_tlast  = S_axis_tlast && block_full_end;
         end
         ST_PAD: begin
            M_axis_tvalid = 1'b1;
            M_axis_tdata  = {4{3'b000, pad_n}};
            M_axis_tlast  = (pad_cnt == 3'd1);
         end
         default: ;
      endcase
      M_axis_tkeep = M_axis_tvalid ? 4'hF : 4'h0;
   end

   // Packet sequencing: key latch, key word count, block position and pad countdown.
   always_ff @(posedge Clk) begin
      if (!Rst_n) begin
         state    <= ST_IDLE;
         key_reg  <= '0;
         key_cnt  <= 2'd0;
         word_idx <= 2'd0;
         pad_cnt  <= 3'd0;
         pad_n    <= 5'd0;
      end else begin
         unique case (state)
            ST_IDLE: begin
               if (S_axis_tvalid) begin
                  key_reg <= Key;
                  key_cnt <= 2'd0;
                  state   <= ST_KEY_OUT;
               end
            end
            ST_KEY_OUT: begin
               if (M_axis_tready) begin
                  key_cnt <= key_cnt + 2'd1;
                  if (key_cnt == 2'd3) begin
                     word_idx <= 2'd0;
                     state    <= ST_DATA;
                  end
               end
            end
            ST_DATA: begin
               if (S_axis_tvalid && M_axis_tready) begin
                  word_idx <= word_idx + 2'd1;
                  if (S_axis_tlast) begin
                     if (block_full_end) begin
                        state <= ST_IDLE;
                     end else begin
                        pad_n   <= n_calc;
                        pad_cnt <= (lane_v == 3'd4 && word_idx == 2'd3) ? 3'd4
                                                                        : {1'b0, 2'd3 - word_idx};
                        state   <= ST_PAD;
                     end
                  end
               end
            end
            ST_PAD: begin
               if (M_axis_tready) begin
                  pad_cnt <= pad_cnt - 3'd1;
                  if (pad_cnt == 3'd1) begin
                     state <= ST_IDLE;
                  end
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_aes_pkcs7_framer.sv
// Bench for aes_pkcs7_framer: a packet-level model predicts every output beat
// (key words, plaintext, PKCS#7 padding) and a monitor compares each handshake.
module tb_aes_pkcs7_framer;

   localparam logic [127:0] KEY_A = 128'h0f0e0d0c0b0a09080706050403020100;
   localparam logic [127:0] KEY_F = {128{1'b1}};

   logic         Clk;
   logic         Rst_n;
   logic [127:0] Key;
   logic [31:0]  S_axis_tdata;
   logic [3:0]   S_axis_tkeep;
   logic         S_axis_tvalid;
   logic         S_axis_tready;
   logic         S_axis_tlast;
   logic [31:0]  M_axis_tdata;
   logic [3:0]   M_axis_tkeep;
   logic         M_axis_tvalid;
   logic         M_axis_tready;
   logic         M_axis_tlast;

   int           n_vec = 0;
   int           n_err = 0;
   int           rdy_mode = 0;
   logic [32:0]  exp_q[$];
   logic [32:0]  obs_q[$];
   logic [7:0]   pb[$];
   logic [31:0]  wq[$];

   aes_pkcs7_framer #(.AXIS_WIDTH(32)) dut (
      .Clk           (Clk),
      .Rst_n         (Rst_n),
      .Key           (Key),
      .S_axis_tdata  (S_axis_tdata),
      .S_axis_tkeep  (S_axis_tkeep),
      .S_axis_tvalid (S_axis_tvalid),
      .S_axis_tready (S_axis_tready),
      .S_axis_tlast  (S_axis_tlast),
      .M_axis_tdata  (M_axis_tdata),
      .M_axis_tkeep  (M_axis_tkeep),
      .M_axis_tvalid (M_axis_tvalid),
      .M_axis_tready (M_axis_tready),
      .M_axis_tlast  (M_axis_tlast)
   );

   initial Clk = 1'b0;
   always #5 Clk = ~Clk;

   initial begin
      #400000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1);
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Packet model: key words, then bytes plus PKCS#7 padding grouped into words.
   task automatic push_model(input logic [127:0] k, input logic [7:0] b[$]);
      logic [7:0] p[$];
      int         n;
      for (int i = 0; i < 4; i++) exp_q.push_back({1'b0, k[32*i +: 32]});
      p = b;
      n = 16 - (b.size() % 16);
      for (int i = 0; i < n; i++) p.push_back(8'(n));
      for (int i = 0; i < p.size(); i += 4)
         exp_q.push_back({(i + 4 == p.size()), p[i+3], p[i+2], p[i+1], p[i]});
   endtask

   // Master-ready pattern: 0 = always ready, 1 = toggle each cycle, 2 = stalled.
   initial begin
      M_axis_tready = 1'b0;
      forever begin
         @(posedge Clk);
         #1;
         case (rdy_mode)
            0:       M_axis_tready = 1'b1;
            1:       M_axis_tready = ~M_axis_tready;
            default: M_axis_tready = 1'b0;
         endcase
      end
   end

   // Output monitor: beat compare, hold-while-stalled, tkeep and tready rules.
   initial begin
      logic        pend;
      logic [32:0] held;
      logic [32:0] e;
      pend = 1'b0;
      held = '0;
      forever begin
         @(negedge Clk);
         if (!Rst_n) begin
            pend = 1'b0;
         end else begin
            if (pend) chk("hold_stable", 64'({M_axis_tvalid, M_axis_tlast, M_axis_tdata}), 64'({1'b1, held}));
            if (M_axis_tvalid) chk("tkeep", 64'(M_axis_tkeep), 64'hF);
            if (S_axis_tready) chk("s_ready_follows_m", 64'(M_axis_tready), 64'd1);
            if (S_axis_tvalid && S_axis_tready) chk("passthru_valid", 64'(M_axis_tvalid), 64'd1);
            if (M_axis_tvalid && M_axis_tready) begin
               obs_q.push_back({M_axis_tlast, M_axis_tdata});
               if (exp_q.size() == 0) begin
                  n_vec++;
                  n_err++;
                  $display("FAIL extra_beat: got %h expected no beat", {M_axis_tlast, M_axis_tdata});
               end else begin
                  e = exp_q.pop_front();
                  chk("beat", 64'({M_axis_tlast, M_axis_tdata}), 64'(e));
               end
            end
            pend = M_axis_tvalid && !M_axis_tready;
            held = {M_axis_tlast, M_axis_tdata};
         end
      end
   end

   task automatic send_words(input logic [31:0] w[$], input logic [3:0] lk);
      int t;
      for (int i = 0; i < w.size(); i++) begin
         S_axis_tdata  = w[i];
         S_axis_tlast  = (i == w.size() - 1);
         S_axis_tkeep  = (i == w.size() - 1) ? lk : 4'hF;
         S_axis_tvalid = 1'b1;
         t = 0;
         forever begin
            @(negedge Clk);
            if (S_axis_tready || t > 300) break;
            t++;
         end
         if (t > 300) begin
            n_vec++;
            n_err++;
            $display("FAIL s_handshake_timeout: got no tready expected tready within 300 cycles");
         end
         @(posedge Clk);
         #1;
      end
      S_axis_tvalid = 1'b0;
      S_axis_tlast  = 1'b0;
      S_axis_tkeep  = 4'h0;
   endtask

   task automatic send_bytes(input logic [7:0] b[$], input logic [7:0] fill);
      logic [31:0] w[$];
      logic [31:0] x;
      int          nb;
      int          rem;
      nb = (b.size() == 0) ? 1 : (b.size() + 3) / 4;
      for (int j = 0; j < nb; j++) begin
         for (int l = 0; l < 4; l++)
            x[8*l +: 8] = (4*j + l < b.size()) ? b[4*j + l] : fill;
         w.push_back(x);
      end
      rem = b.size() - 4 * (nb - 1);
      send_words(w, 4'((1 << rem) - 1));
   endtask

   task automatic drain();
      int t;
      t = 0;
      while (exp_q.size() != 0 && t < 400) begin
         @(negedge Clk);
         t++;
      end
      chk("drain_left", 64'(exp_q.size()), 64'd0);
      exp_q.delete();
      @(posedge Clk);
      #1;
   endtask

   task automatic bytes_seq(input int len, input int start);
      pb.delete();
      for (int i = 0; i < len; i++) pb.push_back(8'(start + i));
   endtask

   task automatic bytes_five();
      pb.delete();
      pb.push_back(8'h11); pb.push_back(8'h22); pb.push_back(8'h33);
      pb.push_back(8'h44); pb.push_back(8'h55);
   endtask

   initial begin
      Rst_n = 1'b0;
      Key = '0;
      S_axis_tdata = '0;
      S_axis_tkeep = '0;
      S_axis_tvalid = 1'b0;
      S_axis_tlast = 1'b0;
      repeat (2) @(posedge Clk);
      @(negedge Clk);
      chk("reset_outputs", 64'({M_axis_tvalid, M_axis_tlast, M_axis_tkeep, M_axis_tdata, S_axis_tready}), 64'd0);
      @(posedge Clk);
      #1;
      Rst_n = 1'b1;
      repeat (2) @(posedge Clk);
      #1;

      // 16-byte aligned packet: full extra pad block
      Key = KEY_A;
      bytes_seq(16, 8'hA0);
      push_model(KEY_A, pb);
      chk("model16_key0", 64'(exp_q[0]), 64'({1'b0, 32'h03020100}));
      chk("model16_last", 64'(exp_q[11]), 64'({1'b1, 32'h10101010}));
      obs_q.delete();
      fork
         send_bytes(pb, 8'h00);
         begin
            @(negedge Clk);
            chk("latency_idle", 64'(M_axis_tvalid), 64'd0);
            @(negedge Clk);
            chk("latency_key", 64'(M_axis_tvalid), 64'd1);
         end
      join
      drain();
      chk("beats16", 64'(obs_q.size()), 64'd12);
      chk("obs16_key3", 64'(obs_q[3]), 64'({1'b0, 32'h0f0e0d0c}));
      chk("obs16_pad_mid", 64'(obs_q[10]), 64'({1'b0, 32'h10101010}));
      chk("obs16_last", 64'(obs_q[11]), 64'({1'b1, 32'h10101010}));

      // 5-byte packet
      bytes_five();
      push_model(KEY_A, pb);
      chk("model5_last", 64'(exp_q[7]), 64'({1'b1, 32'h0b0b0b0b}));
      obs_q.delete();
      send_bytes(pb, 8'h00);
      drain();
      chk("beats5", 64'(obs_q.size()), 64'd8);
      chk("obs5_merge", 64'(obs_q[5]), 64'({1'b0, 32'h0b0b0b55}));

      // 15-byte packet: pad fits in the last beat, no pad beats
      bytes_seq(12, 0);
      pb.push_back(8'haa); pb.push_back(8'hbb); pb.push_back(8'hcc);
      push_model(KEY_A, pb);
      obs_q.delete();
      send_bytes(pb, 8'h00);
      drain();
      chk("beats15", 64'(obs_q.size()), 64'd8);
      chk("obs15_last", 64'(obs_q[7]), 64'({1'b1, 32'h01ccbbaa}));

      // 5-byte packet under toggling backpressure
      rdy_mode = 1;
      bytes_five();
      push_model(KEY_A, pb);
      obs_q.delete();
      send_bytes(pb, 8'h00);
      drain();
      rdy_mode = 0;
      chk("beats5_bp", 64'(obs_q.size()), 64'd8);
      chk("obs5_bp_merge", 64'(obs_q[5]), 64'({1'b0, 32'h0b0b0b55}));
      repeat (2) @(posedge Clk);
      #1;

      // Zero-length packet: single beat with tkeep 0
      pb.delete();
      push_model(KEY_A, pb);
      chk("model0_first_pad", 64'(exp_q[4]), 64'({1'b0, 32'h10101010}));
      obs_q.delete();
      send_bytes(pb, 8'hde);
      drain();
      chk("beats0", 64'(obs_q.size()), 64'd8);

      // Hole in tkeep: only lane 0 counts, lanes above are padded
      pb.delete();
      pb.push_back(8'h11);
      push_model(KEY_A, pb);
      wq.delete();
      wq.push_back(32'h44332211);
      obs_q.delete();
      send_words(wq, 4'b1101);
      drain();
      chk("obs_hole", 64'(obs_q[4]), 64'({1'b0, 32'h0f0f0f11}));

      // 20-byte packet: full last beat mid-block, pad 12
      bytes_seq(20, 8'h30);
      push_model(KEY_A, pb);
      obs_q.delete();
      send_bytes(pb, 8'hee);
      drain();
      chk("beats20", 64'(obs_q.size()), 64'd12);
      chk("obs20_pad", 64'(obs_q[9]), 64'({1'b0, 32'h0c0c0c0c}));

      // Key change during packet 1, packet 2 back-to-back
      Key = KEY_A;
      bytes_five();
      push_model(KEY_A, pb);
      push_model(KEY_F, pb);
      obs_q.delete();
      fork
         send_bytes(pb, 8'h00);
         begin
            repeat (3) @(posedge Clk);
            #1;
            Key = KEY_F;
         end
      join
      send_bytes(pb, 8'h00);
      drain();
      chk("beats_keychg", 64'(obs_q.size()), 64'd16);
      chk("obs_old_key", 64'(obs_q[0]), 64'({1'b0, 32'h03020100}));
      chk("obs_new_key0", 64'(obs_q[8]), 64'({1'b0, 32'hffffffff}));
      chk("obs_new_key3", 64'(obs_q[11]), 64'({1'b0, 32'hffffffff}));

      // Reset during the pad phase
      Key = KEY_A;
      pb.delete();
      pb.push_back(8'h5a);
      push_model(KEY_A, pb);
      send_bytes(pb, 8'h00);
      rdy_mode = 2;
      @(posedge Clk);
      #1;
      Rst_n = 1'b0;
      @(posedge Clk);
      #1;
      Rst_n = 1'b1;
      @(negedge Clk);
      chk("midpkt_reset_outputs", 64'({M_axis_tvalid, M_axis_tlast, M_axis_tkeep, M_axis_tdata, S_axis_tready}), 64'd0);
      exp_q.delete();
      rdy_mode = 0;
      @(posedge Clk);
      #1;
      bytes_five();
      push_model(KEY_A, pb);
      obs_q.delete();
      send_bytes(pb, 8'h00);
      drain();
      chk("beats_after_reset", 64'(obs_q.size()), 64'd8);
      chk("obs_after_reset_key0", 64'(obs_q[0]), 64'({1'b0, 32'h03020100}));

      repeat (3) @(posedge Clk);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/aes_pkcs7_framer.md
# aes_pkcs7_framer

Upstream framing stage for the AES-128 ECB iterative core. It takes an arbitrary-length plaintext packet and prepends the 128-bit key as four 32-bit beats. It then forwards the plaintext and appends PKCS#7 padding so that each packet ends on a 16-byte block boundary, with tlast on the final padded beat. The output stream matches the core's input protocol: key, then whole blocks, then tlast, then key again.

## Interface
- AXIS_WIDTH, 32, data width of both streams in bits. Only 32 is supported.
- Clk  input  1  clock; every register updates on the rising edge.
- Rst_n  input  1  reset, synchronous and active-low.
- Key  input  128  key for the next packet. Key[7:0] is key byte 0. The block samples Key at packet start.
- S_axis  axis_if.slave  32  plaintext input (tdata, tkeep, tvalid, tready, tlast).
  - Byte lane 0 = tdata[7:0] is the first byte.
  - tkeep is evaluated only on the tlast beat; all other beats are treated as full.
- M_axis  axis_if.master  32  framed output to the AES core. tkeep is always 4'hF while tvalid is high.

## Operation
- States: ST_IDLE, ST_KEY_OUT, ST_DATA, ST_PAD (one-hot).
- ST_IDLE
  - S tready = 0, M tvalid = 0.
  - When S tvalid = 1: latch Key into key_reg, clear key_cnt, go to ST_KEY_OUT.
- ST_KEY_OUT
  - M tvalid = 1, M tdata = key_reg word key_cnt, in order [31:0], [63:32], [95:64], [127:96]. M tlast = 0. S tready = 0.
  - Each M handshake increments key_cnt. The handshake at key_cnt = 3 goes to ST_DATA with word_idx = 0.
- ST_DATA (combinational pass-through)
  - M tvalid = S tvalid, S tready = M tready.
  - word_idx (2 bits, wraps 3 -> 0) increments on each handshake and gives the beat position within the current block.
  - Non-tlast beats: M tdata = S tdata, M tlast = 0.
  - tlast beat: v = number of contiguous ones in tkeep starting at lane 0 (0..4). Any lane at or above v is treated as invalid. Pad value N = 16 - (4*word_idx + v), range 1..16.
    - Output lanes at or above v are replaced by byte N.
    - If v < 4 and word_idx = 3: M tlast = 1, go to ST_IDLE.
    - Otherwise: M tlast = 0, pad_cnt = 3 - word_idx (or 4 when v = 4 and word_idx = 3), go to ST_PAD.
- ST_PAD
  - M tvalid = 1, M tdata = {4{N}}, S tready = 0.
  - pad_cnt decrements on each M handshake. M tlast = 1 when pad_cnt = 1; that handshake goes to ST_IDLE.
- N is held in a 5-bit register, zero-extended into each byte lane (0x10 for 16).
- A Key change during a packet is ignored until the next entry into ST_KEY_OUT.

## Timing
- Reset values: M tvalid 0, tdata 0, tkeep 0, tlast 0; S tready 0.
- Internal reset values: state ST_IDLE, key_reg 0, all counters 0.
- A reset mid-packet abandons the packet with no tlast emitted. The AES core shares the reset and restarts in its key state.
- Latency:
  - First key beat: M tvalid rises 1 cycle after S tvalid is first seen in ST_IDLE.
  - ST_DATA adds 0 cycles (combinational).
  - The first pad beat is valid in the cycle after the tlast handshake.
- AXIS rules: M tdata and M tlast are stable while M tvalid = 1 and M tready = 0. M tvalid never drops without a handshake.
- Back-to-back packets: after the tlast handshake, the block passes through ST_IDLE for at least 1 cycle before the next key beat.
- Output beats per packet: 4 + 4 * ceil((L+1)/16), where L is the packet length in bytes.
- Edge case: a single tlast beat with tkeep = 0 is a 0-byte packet and produces the key plus one block of 0x10 bytes.

## Test plan
- Key = 0x0f0e…0100, 16-byte packet (4 full beats).
  - Expect 12 beats: 0x03020100, 0x07060504, 0x0b0a0908, 0x0f0e0d0c, then the 4 data beats, then 4 × 0x10101010 with tlast on beat 12 only.
- 5-byte packet: 0x44332211 (keep F), then 0x00000055 (keep 1, tlast).
  - Expect 4 key beats, then 0x44332211, 0x0b0b0b55, 0x0b0b0b0b, 0x0b0b0b0b (tlast).
- 15-byte packet: last beat 0x00ccbbaa (keep 7, word_idx 3).
  - Expect output 0x01ccbbaa with tlast and no pad beats. The block then returns to ST_IDLE.
- Backpressure: M tready toggling 1/0 every cycle over the 5-byte case.
  - Expect identical beat sequence and tdata held stable while stalled.
  - S tready equals M tready in ST_DATA and is 0 in other states.
- Key changed to 0xffff…ff during packet 1, then packet 2 sent.
  - Expect packet 1 key beats to use the old key and packet 2 key beats all 0xffffffff.
- Rst_n = 0 for 1 cycle during ST_PAD.
  - Expect all outputs 0 on the next cycle. The next packet starts with 4 key beats.
